// File: rtl/ysyx_22050039_core_ctrl_pkg.sv
// Shared types for the core sequencer: FSM state encoding and halt reason codes.
package ysyx_22050039_core_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        MDU    = 3'd3,
        MREQ   = 3'd4,
        MWAIT  = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } ctrl_state_t;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_INVALID = 2'b10;
    localparam logic [1:0] HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/ysyx_22050039_wdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags the
// final permitted cycle so the sequencer can give up on a stalled handshake.
module ysyx_22050039_wdog #(
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    // Expiry is only meaningful while waiting; the caller lets a same-cycle event win.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ysyx_22050039_core_ctrl.sv
// Multi-cycle instruction sequencer for the RV64 core: walks each instruction through
// fetch/decode/execute/memory/writeback, drives the IFU/MDU/LSU handshakes and the PC/GPR strobes.
module ysyx_22050039_core_ctrl
    import ysyx_22050039_core_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    input  logic            ifu_resp_valid,
    output logic            inst_latch_en,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_muldiv,
    input  logic            dec_reg_wen,
    input  logic            dec_ebreak,
    input  logic            dec_invalid,
    output logic            mdu_start,
    input  logic            mdu_done,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_resp_valid,
    output logic            pc_we,
    output logic            reg_we,
    output logic            retire,
    output logic            halted,
    output logic [1:0]      halt_code,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt,
    output ctrl_state_t     dbg_state
);

    // Handshakes: a request valid is raised in its state and held until the cycle its
    // ready is seen high; responses/done are single-cycle and only honoured in the state
    // that waits for them, so anything early, late or stray is simply ignored.

    ctrl_state_t       state, state_next;
    logic [1:0]        halt_code_q, halt_code_next;
    logic [XLEN-1:0]   cycle_q, instret_q;
    logic              retire_raw;
    logic              wdog_en, wdog_clr, wdog_expire;

    ysyx_22050039_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (wdog_expire)
    );

    assign wdog_en  = (state == FETCH) || (state == FWAIT) || (state == MDU) ||
                      (state == MREQ)  || (state == MWAIT);
    assign wdog_clr = (state_next != state);

    // State register, halt reason and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            halt_code_q <= HALT_NONE;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state <= state_next;
            if (state != HALT && state_next == HALT) begin
                halt_code_q <= halt_code_next;
            end
            if (state != HALT) begin
                cycle_q <= cycle_q + XLEN'(1);
            end
            if (retire_raw) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state;
        halt_code_next = HALT_NONE;
        case (state)
            FETCH:  if (ifu_req_ready)  state_next = FWAIT;
            FWAIT:  if (ifu_resp_valid) state_next = DECODE;
            DECODE: begin
                if (dec_invalid) begin
                    state_next     = HALT;
                    halt_code_next = HALT_INVALID;
                end else if (dec_ebreak) begin
                    state_next     = HALT;
                    halt_code_next = HALT_EBREAK;
                end else if (dec_muldiv) begin
                    state_next = MDU;
                end else if (dec_load || dec_store) begin
                    state_next = MREQ;
                end else begin
                    state_next = WB;
                end
            end
            MDU:    if (mdu_done)       state_next = WB;
            MREQ:   if (lsu_req_ready)  state_next = MWAIT;
            MWAIT:  if (lsu_resp_valid) state_next = WB;
            WB:     state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = HALT;
        endcase
        // A handshake completing on the last permitted cycle still wins over the timeout.
        if (wdog_expire && state_next == state) begin
            state_next     = HALT;
            halt_code_next = HALT_TIMEOUT;
        end
    end

    // Output decode: Moore per state, plus the Mealy strobes in FWAIT and DECODE
    always_comb begin
        ifu_req_valid = 1'b0;
        inst_latch_en = 1'b0;
        mdu_start     = 1'b0;
        lsu_req_valid = 1'b0;
        pc_we         = 1'b0;
        reg_we        = 1'b0;
        retire_raw    = 1'b0;
        case (state)
            FETCH:  ifu_req_valid = 1'b1;
            FWAIT:  inst_latch_en = ifu_resp_valid;
            DECODE: begin
                retire_raw = !dec_invalid && dec_ebreak;
                mdu_start  = !dec_invalid && !dec_ebreak && dec_muldiv;
            end
            MREQ:   lsu_req_valid = 1'b1;
            WB: begin
                pc_we      = 1'b1;
                reg_we     = dec_reg_wen;
                retire_raw = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            ifu_req_valid = 1'b0;
            inst_latch_en = 1'b0;
            mdu_start     = 1'b0;
            lsu_req_valid = 1'b0;
            pc_we         = 1'b0;
            reg_we        = 1'b0;
            retire_raw    = 1'b0;
        end
    end

    assign retire      = retire_raw;
    assign halted      = !rst && (state == HALT);
    assign halt_code   = rst ? HALT_NONE : halt_code_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_ysyx_22050039_core_ctrl.sv
// Self-checking bench for the core sequencer: directed scenarios plus randomized
// instruction streams checked against a transaction-level schedule of expected strobes.
module tb_ysyx_22050039_core_ctrl;
    import ysyx_22050039_core_ctrl_pkg::*;

    localparam int XLEN       = 64;
    localparam int WDOG_W     = 16;
    localparam int WDOG_LIMIT = 12;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_MUL = 3;

    // Expected-strobe vector bits
    localparam logic [7:0] V_IFU   = 8'h80;
    localparam logic [7:0] V_LATCH = 8'h40;
    localparam logic [7:0] V_MST   = 8'h20;
    localparam logic [7:0] V_LSU   = 8'h10;
    localparam logic [7:0] V_PC    = 8'h08;
    localparam logic [7:0] V_REG   = 8'h04;
    localparam logic [7:0] V_RET   = 8'h02;
    localparam logic [7:0] V_HALT  = 8'h01;
    localparam logic [7:0] V_NONE  = 8'h00;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid, inst_latch_en;
    logic            dec_load, dec_store, dec_muldiv, dec_reg_wen, dec_ebreak, dec_invalid;
    logic            mdu_start, mdu_done;
    logic            lsu_req_valid, lsu_req_ready, lsu_resp_valid;
    logic            pc_we, reg_we, retire, halted;
    logic [1:0]      halt_code;
    logic [XLEN-1:0] cycle_cnt, instret_cnt;
    ctrl_state_t     dbg_state;
    logic [7:0]      strobes;

    assign strobes = {ifu_req_valid, inst_latch_en, mdu_start, lsu_req_valid,
                      pc_we, reg_we, retire, halted};

    ysyx_22050039_core_ctrl #(
        .XLEN       (XLEN),
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .inst_latch_en  (inst_latch_en),
        .dec_load       (dec_load),
        .dec_store      (dec_store),
        .dec_muldiv     (dec_muldiv),
        .dec_reg_wen    (dec_reg_wen),
        .dec_ebreak     (dec_ebreak),
        .dec_invalid    (dec_invalid),
        .mdu_start      (mdu_start),
        .mdu_done       (mdu_done),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .pc_we          (pc_we),
        .reg_we         (reg_we),
        .retire         (retire),
        .halted         (halted),
        .halt_code      (halt_code),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [63:0] exp_cyc  = '0;
    logic [63:0] exp_ret  = '0;
    logic [1:0]  exp_code = HALT_NONE;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle's outputs against expectation, then advances the model.
    task automatic tick(input string tag, input logic [7:0] ev);
        #1;
        chk({tag, " strobes"},     64'(strobes),   64'(ev));
        chk({tag, " cycle_cnt"},   cycle_cnt,      exp_cyc);
        chk({tag, " instret_cnt"}, instret_cnt,    exp_ret);
        chk({tag, " halt_code"},   64'(halt_code), 64'(exp_code));
        if (!ev[0]) exp_cyc++;
        if (ev[1])  exp_ret++;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_hs();
        ifu_req_ready  = 1'($urandom_range(0, 1));
        ifu_resp_valid = 1'($urandom_range(0, 1));
        mdu_done       = 1'($urandom_range(0, 1));
        lsu_req_ready  = 1'($urandom_range(0, 1));
        lsu_resp_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_dec();
        dec_load    = 1'($urandom_range(0, 1));
        dec_store   = 1'($urandom_range(0, 1));
        dec_muldiv  = 1'($urandom_range(0, 1));
        dec_reg_wen = 1'($urandom_range(0, 1));
        dec_ebreak  = 1'($urandom_range(0, 1));
        dec_invalid = 1'($urandom_range(0, 1));
    endtask

    task automatic set_dec(input int kind, input bit wen);
        dec_load    = (kind == K_LOAD);
        dec_store   = (kind == K_STORE);
        dec_muldiv  = (kind == K_MUL);
        dec_reg_wen = wen;
        dec_ebreak  = 1'b0;
        dec_invalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_hs();
        rand_dec();
        @(negedge clk);
        rand_hs();
        #1;
        chk("reset strobes",   64'(strobes),   64'(V_NONE));
        chk("reset halt_code", 64'(halt_code), 64'(HALT_NONE));
        chk("reset state",     64'(dbg_state), 64'(FETCH));
        chk("reset counters",  cycle_cnt | instret_cnt, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        exp_cyc  = '0;
        exp_ret  = '0;
        exp_code = HALT_NONE;
    endtask

    // FETCH waits d_if cycles for ready; FWAIT waits d_rsp cycles for the response.
    task automatic fetch_phase(input int d_if, input int d_rsp);
        for (int i = 0; i <= d_if; i++) begin
            rand_hs();
            rand_dec();
            ifu_req_ready = (i == d_if);
            tick("fetch", V_IFU);
        end
        for (int i = 0; i <= d_rsp; i++) begin
            rand_hs();
            rand_dec();
            ifu_resp_valid = (i == d_rsp);
            tick("fwait", (i == d_rsp) ? V_LATCH : V_NONE);
        end
    endtask

    task automatic run_inst(input int kind, input bit wen, input int d_if, input int d_rsp,
                            input int d_x1, input int d_x2);
        fetch_phase(d_if, d_rsp);
        rand_hs();
        set_dec(kind, wen);
        tick("decode", (kind == K_MUL) ? V_MST : V_NONE);
        if (kind == K_MUL) begin
            for (int i = 0; i <= d_x1; i++) begin
                rand_hs();
                mdu_done = (i == d_x1);
                tick("mdu", V_NONE);
            end
        end else if (kind == K_LOAD || kind == K_STORE) begin
            for (int i = 0; i <= d_x1; i++) begin
                rand_hs();
                lsu_req_ready = (i == d_x1);
                tick("mreq", V_LSU);
            end
            for (int i = 0; i <= d_x2; i++) begin
                rand_hs();
                lsu_resp_valid = (i == d_x2);
                tick("mwait", V_NONE);
            end
        end
        rand_hs();
        tick("wb", V_PC | V_RET | (wen ? V_REG : V_NONE));
    endtask

    task automatic halt_phase(input int n);
        for (int i = 0; i < n; i++) begin
            rand_hs();
            rand_dec();
            tick("halt", V_HALT);
        end
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 7) == 0) return WDOG_LIMIT - 1;
        return int'($urandom_range(0, 4));
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        rand_hs();
        rand_dec();
        do_reset();

        // Minimum-latency ALU op: WB lands in cycle 3, counters 4/1 in cycle 4.
        run_inst(K_ALU, 1'b1, 0, 0, 0, 0);
        // Load with lsu_req_ready low for 3 cycles.
        run_inst(K_LOAD, 1'b1, 0, 0, 3, 2);
        // Muldiv finishing 10 cycles after the start pulse.
        run_inst(K_MUL, 1'b1, 1, 1, 9, 0);
        run_inst(K_STORE, 1'b0, 2, 0, 0, 0);

        // Reset pulsed while waiting in MWAIT; late response must be ignored.
        fetch_phase(0, 0);
        rand_hs();
        set_dec(K_LOAD, 1'b1);
        tick("decode", V_NONE);
        rand_hs();
        lsu_req_ready = 1'b1;
        tick("mreq", V_LSU);
        rand_hs();
        lsu_resp_valid = 1'b0;
        tick("mwait", V_NONE);
        rst = 1'b1;
        rand_hs();
        lsu_resp_valid = 1'b1;
        #1;
        chk("rst in mwait strobes", 64'(strobes), 64'(V_NONE));
        @(negedge clk);
        rst      = 1'b0;
        exp_cyc  = '0;
        exp_ret  = '0;
        exp_code = HALT_NONE;
        rand_hs();
        lsu_resp_valid = 1'b1;
        mdu_done       = 1'b1;
        ifu_req_ready  = 1'b0;
        #1;
        chk("post-rst state", 64'(dbg_state), 64'(FETCH));
        tick("post-rst", V_IFU);
        run_inst(K_ALU, 1'b0, 0, 1, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            run_inst(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     rand_delay(), rand_delay(), rand_delay(), rand_delay());
        end

        // Responses on the last permitted wait cycle: no timeout.
        run_inst(K_LOAD, 1'b1, WDOG_LIMIT - 1, WDOG_LIMIT - 1, WDOG_LIMIT - 1, WDOG_LIMIT - 1);

        // IFU response never arrives: timeout after WDOG_LIMIT FWAIT cycles.
        rand_hs();
        rand_dec();
        ifu_req_ready = 1'b1;
        tick("fetch", V_IFU);
        for (int i = 0; i < WDOG_LIMIT; i++) begin
            rand_hs();
            rand_dec();
            ifu_resp_valid = 1'b0;
            tick("fwait to", V_NONE);
        end
        exp_code = HALT_TIMEOUT;
        halt_phase(5);
        do_reset();

        // ebreak: retires, halts with code 01, no fetch for 20 cycles.
        run_inst(K_ALU, 1'b1, 0, 0, 0, 0);
        fetch_phase(1, 2);
        rand_hs();
        set_dec(K_ALU, 1'b1);
        dec_ebreak = 1'b1;
        tick("ebreak", V_RET);
        exp_code = HALT_EBREAK;
        halt_phase(20);
        do_reset();

        // invalid together with ebreak: invalid wins, nothing retires.
        fetch_phase(0, 0);
        rand_hs();
        set_dec(K_MUL, 1'b1);
        dec_ebreak  = 1'b1;
        dec_invalid = 1'b1;
        tick("invalid", V_NONE);
        exp_code = HALT_INVALID;
        halt_phase(5);
        do_reset();
        run_inst(K_ALU, 1'b1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
